ese_flash_cmd_monitor: RTL and testbench



---
 rtl/ese_flash_pkg.sv | 45 ++++
 rtl/flash_busy_timer.sv | 28 ++
 rtl/ese_flash_cmd_monitor.sv | 159 +++++++++++++++
 tb/tb_ese_flash_cmd_monitor.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ese_flash_pkg.sv
// Shared encodings for the cartridge flash command monitor: FSM states,
// JEDEC command bytes, unlock addresses and last-operation codes.
package ese_flash_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_U1   = 3'd1,
        ST_U2   = 3'd2,
        ST_PROG = 3'd3,
        ST_E0   = 3'd4,
        ST_E1   = 3'd5,
        ST_E2   = 3'd6,
        ST_BUSY = 3'd7
    } state_e;

    typedef enum logic [1:0] {
        OP_NONE   = 2'b00,
        OP_PROG   = 2'b01,
        OP_SECTOR = 2'b10,
        OP_CHIP   = 2'b11
    } last_op_e;

    localparam logic [DATA_W-1:0] CMD_UNLOCK1 = 8'hAA;
    localparam logic [DATA_W-1:0] CMD_UNLOCK2 = 8'h55;
    localparam logic [DATA_W-1:0] CMD_PROG    = 8'hA0;
    localparam logic [DATA_W-1:0] CMD_ERASE   = 8'h80;
    localparam logic [DATA_W-1:0] CMD_CHIP    = 8'h10;
    localparam logic [DATA_W-1:0] CMD_SECTOR  = 8'h30;
    localparam logic [DATA_W-1:0] CMD_ID      = 8'h90;
    localparam logic [DATA_W-1:0] CMD_RESET   = 8'hF0;

    localparam logic [ADDR_W-1:0] ADDR_UNL1 = 16'h5555;
    localparam logic [ADDR_W-1:0] ADDR_UNL2 = 16'h4AAA;
    localparam logic [ADDR_W-1:0] WIN_LO    = 16'h4000;
    localparam logic [ADDR_W-1:0] WIN_HI    = 16'hBFFF;

    // Flash is only reachable through the 4000h-BFFFh slot window.
    function automatic logic in_win(input logic [ADDR_W-1:0] a);
        return (a >= WIN_LO) && (a <= WIN_HI);
    endfunction

endpackage

// File: rtl/flash_busy_timer.sv
// Down-counter timing one program/erase operation; expire fires on the
// decrement clock where the count leaves 1.
module flash_busy_timer #(
    parameter int unsigned CNT_W = 19
) (
    input  logic             SLT_CLOCK,
    input  logic             SLT_RESETn,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             expire_c_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge SLT_CLOCK or negedge SLT_RESETn) begin
        if (!SLT_RESETn) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign expire_c_o = dec_i && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/ese_flash_cmd_monitor.sv
// Snoops slot writes, tracks the JEDEC unlock/program/erase sequences and
// times the resulting flash operation, blocking flash writes while busy.
module ese_flash_cmd_monitor
    import ese_flash_pkg::*;
#(
    parameter int unsigned PROG_CYCLES   = 72,
    parameter int unsigned SECTOR_CYCLES = 89500,
    parameter int unsigned CHIP_CYCLES   = 358000,
    parameter int unsigned CNT_W         = 19
) (
    input  logic              SLT_CLOCK,
    input  logic              SLT_RESETn,
    input  logic              SLT_SLTSL,
    input  logic              SLT_WEn,
    input  logic [ADDR_W-1:0] SLT_A,
    input  logic [DATA_W-1:0] SLT_D,
    input  logic              FLASH_CTRL_EN,
    output logic              FLASH_BUSY,
    output logic              OP_DONE,
    output logic [1:0]        LAST_OP,
    output logic              CMD_ERR,
    output logic              WR_BLOCK
);

    state_e           state_q, state_d;
    last_op_e         last_op_q, last_op_d;
    logic             err_q, err_d;
    logic             wr_act_q;
    logic             busy_q;
    logic             done_q;
    logic             wr_act_c, ev_c, unl1_c, unl2_c;
    logic             load_c, expire_c;
    logic [CNT_W-1:0] load_val_c;

    // One event per strobe-low period, qualified by the flash window.
    assign wr_act_c = ~SLT_SLTSL & ~SLT_WEn;
    assign ev_c     = wr_act_c & ~wr_act_q & in_win(SLT_A);
    assign unl1_c   = (SLT_A == ADDR_UNL1);
    assign unl2_c   = (SLT_A == ADDR_UNL2);

    always_ff @(posedge SLT_CLOCK or negedge SLT_RESETn) begin
        if (!SLT_RESETn) begin
            state_q   <= ST_IDLE;
            last_op_q <= OP_NONE;
            err_q     <= 1'b0;
            wr_act_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_op_q <= last_op_d;
            err_q     <= err_d;
            wr_act_q  <= wr_act_c;
            busy_q    <= (state_d == ST_BUSY);
            done_q    <= expire_c;
        end
    end

    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        last_op_d  = last_op_q;
        load_c     = 1'b0;
        load_val_c = '0;
        if (state_q == ST_BUSY) begin
            // The flash is physically busy: writes are errors, never commands.
            if (ev_c) begin
                err_d = 1'b1;
            end
            if (expire_c) begin
                state_d = ST_IDLE;
            end
        end else if (!FLASH_CTRL_EN) begin
            state_d = ST_IDLE;
        end else if (ev_c) begin
            if (SLT_D == CMD_RESET) begin
                state_d = ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (unl1_c && (SLT_D == CMD_UNLOCK1)) begin
                            state_d = ST_U1;
                            err_d   = 1'b0;
                        end
                    end
                    ST_U1, ST_E1: begin
                        if (unl2_c && (SLT_D == CMD_UNLOCK2)) begin
                            state_d = (state_q == ST_U1) ? ST_U2 : ST_E2;
                        end else begin
                            state_d = ST_IDLE;
                            err_d   = 1'b1;
                        end
                    end
                    ST_U2: begin
                        if (unl1_c && (SLT_D == CMD_PROG)) begin
                            state_d = ST_PROG;
                        end else if (unl1_c && (SLT_D == CMD_ERASE)) begin
                            state_d = ST_E0;
                        end else if (unl1_c && (SLT_D == CMD_ID)) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_IDLE;
                            err_d   = 1'b1;
                        end
                    end
                    ST_PROG: begin
                        state_d    = ST_BUSY;
                        load_c     = 1'b1;
                        load_val_c = CNT_W'(PROG_CYCLES);
                        last_op_d  = OP_PROG;
                    end
                    ST_E0: begin
                        if (unl1_c && (SLT_D == CMD_UNLOCK1)) begin
                            state_d = ST_E1;
                        end else begin
                            state_d = ST_IDLE;
                            err_d   = 1'b1;
                        end
                    end
                    ST_E2: begin
                        if (unl1_c && (SLT_D == CMD_CHIP)) begin
                            state_d    = ST_BUSY;
                            load_c     = 1'b1;
                            load_val_c = CNT_W'(CHIP_CYCLES);
                            last_op_d  = OP_CHIP;
                        end else if (SLT_D == CMD_SECTOR) begin
                            state_d    = ST_BUSY;
                            load_c     = 1'b1;
                            load_val_c = CNT_W'(SECTOR_CYCLES);
                            last_op_d  = OP_SECTOR;
                        end else begin
                            state_d = ST_IDLE;
                            err_d   = 1'b1;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    flash_busy_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .SLT_CLOCK  (SLT_CLOCK),
        .SLT_RESETn (SLT_RESETn),
        .load_i     (load_c),
        .load_val_i (load_val_c),
        .dec_i      (state_q == ST_BUSY),
        .expire_c_o (expire_c)
    );

    assign FLASH_BUSY = busy_q;
    assign OP_DONE    = done_q;
    assign LAST_OP    = last_op_q;
    assign CMD_ERR    = err_q;
    assign WR_BLOCK   = busy_q | ~FLASH_CTRL_EN;

endmodule

// File: tb/tb_ese_flash_cmd_monitor.sv
// Directed plus randomized bench for ese_flash_cmd_monitor, checked against a
// command-sequence reference model built on a queue of accepted writes.
module tb_ese_flash_cmd_monitor;

    localparam int PROG = 72;
    localparam int SEC  = 300;
    localparam int CHIP = 600;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sltsl, wen, ctrl_en;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        FLASH_BUSY, OP_DONE, CMD_ERR, WR_BLOCK;
    logic [1:0]  LAST_OP;

    always #5 clk = ~clk;

    ese_flash_cmd_monitor #(
        .PROG_CYCLES   (PROG),
        .SECTOR_CYCLES (SEC),
        .CHIP_CYCLES   (CHIP),
        .CNT_W         (19)
    ) dut (
        .SLT_CLOCK     (clk),
        .SLT_RESETn    (rst_n),
        .SLT_SLTSL     (sltsl),
        .SLT_WEn       (wen),
        .SLT_A         (addr),
        .SLT_D         (data),
        .FLASH_CTRL_EN (ctrl_en),
        .FLASH_BUSY    (FLASH_BUSY),
        .OP_DONE       (OP_DONE),
        .LAST_OP       (LAST_OP),
        .CMD_ERR       (CMD_ERR),
        .WR_BLOCK      (WR_BLOCK)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int dut_busy_cnt = 0;
    int dut_done_cnt = 0;

    // Address kind: 0 = 5555h, 1 = 4AAAh, 2 = any window address; data -1 = any.
    int seq_k [4][6] = '{'{0, 1, 0, 2, 0, 0}, '{0, 1, 0, 0, 1, 2},
                         '{0, 1, 0, 0, 1, 0}, '{0, 1, 0, 0, 0, 0}};
    int seq_d [4][6] = '{'{'hAA, 'h55, 'hA0, -1, 0, 0},
                         '{'hAA, 'h55, 'h80, 'hAA, 'h55, 'h30},
                         '{'hAA, 'h55, 'h80, 'hAA, 'h55, 'h10},
                         '{'hAA, 'h55, 'h90, 0, 0, 0}};
    int seq_len [4] = '{4, 6, 6, 3};
    int seq_cyc [4] = '{PROG, SEC, CHIP, 0};

    int          m_rem;
    bit          m_err, m_done, m_act;
    logic [1:0]  m_op;
    logic [15:0] qa[$];
    logic [7:0]  qd[$];

    function automatic bit step_ok(int s, int p, logic [15:0] a, logic [7:0] d);
        bit aok;
        case (seq_k[s][p])
            0:       aok = (a == 16'h5555);
            1:       aok = (a == 16'h4AAA);
            default: aok = 1'b1;
        endcase
        return aok && ((seq_d[s][p] < 0) || (d == 8'(seq_d[s][p])));
    endfunction

    task automatic model_reset();
        m_rem = 0; m_err = 1'b0; m_done = 1'b0; m_act = 1'b0; m_op = 2'b00;
        qa.delete(); qd.delete();
    endtask

    task automatic model_write(input logic [15:0] a, input logic [7:0] d);
        bit prefix = 1'b0;
        int done_s = -1;
        if (d == 8'hF0) begin
            qa.delete(); qd.delete();
            return;
        end
        qa.push_back(a); qd.push_back(d);
        for (int s = 0; s < 4; s++) begin
            bit ok = (qa.size() <= seq_len[s]);
            for (int p = 0; p < qa.size() && ok; p++) ok = step_ok(s, p, qa[p], qd[p]);
            if (ok) begin
                if (qa.size() == seq_len[s]) done_s = s;
                else prefix = 1'b1;
            end
        end
        if (done_s >= 0) begin
            if (done_s < 3) begin
                m_rem = seq_cyc[done_s];
                m_op  = 2'(done_s + 1);
            end
            qa.delete(); qd.delete();
        end else if (prefix) begin
            if (qa.size() == 1) m_err = 1'b0;
        end else begin
            if (qa.size() > 1) m_err = 1'b1;
            qa.delete(); qd.delete();
        end
    endtask

    task automatic model_edge();
        bit act, pulse, win;
        m_done = 1'b0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        act   = !sltsl && !wen;
        pulse = act && !m_act;
        m_act = act;
        win   = (addr >= 16'h4000) && (addr <= 16'hBFFF);
        if (m_rem > 0) begin
            if (pulse && win) m_err = 1'b1;
            m_rem--;
            if (m_rem == 0) m_done = 1'b1;
        end else if (!ctrl_en) begin
            qa.delete(); qd.delete();
        end else if (pulse && win) begin
            model_write(addr, data);
        end
    endtask

    task automatic check_all();
        bit eb = (m_rem > 0);
        bit ew = eb || !ctrl_en;
        n_cmp += 5;
        assert (FLASH_BUSY === eb) else begin
            n_bad++; $error("FAIL busy obs=%0b exp=%0b t=%0t", FLASH_BUSY, eb, $time);
        end
        assert (OP_DONE === m_done) else begin
            n_bad++; $error("FAIL op_done obs=%0b exp=%0b t=%0t", OP_DONE, m_done, $time);
        end
        assert (LAST_OP === m_op) else begin
            n_bad++; $error("FAIL last_op obs=%0b exp=%0b t=%0t", LAST_OP, m_op, $time);
        end
        assert (CMD_ERR === m_err) else begin
            n_bad++; $error("FAIL cmd_err obs=%0b exp=%0b t=%0t", CMD_ERR, m_err, $time);
        end
        assert (WR_BLOCK === ew) else begin
            n_bad++; $error("FAIL wr_block obs=%0b exp=%0b t=%0t", WR_BLOCK, ew, $time);
        end
        if (FLASH_BUSY === 1'b1) dut_busy_cnt++;
        if (OP_DONE === 1'b1) dut_done_cnt++;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++; $error("FAIL %s obs=%0d exp=%0d t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d, input int hold = 1);
        addr = a; data = d; sltsl = 1'b0; wen = 1'b0;
        repeat (hold) tick();
        wen = 1'b1; sltsl = 1'b1;
        tick();
    endtask

    task automatic unlock(input int h = 1);
        wr(16'h5555, 8'hAA, h);
        wr(16'h4AAA, 8'h55, h);
    endtask

    task automatic wait_idle();
        while (m_rem > 0) tick();
    endtask

    function automatic logic [15:0] rand_win();
        return 16'($urandom_range(16'h4000, 16'hBFFF));
    endfunction

    int kind, h, pick;
    logic [15:0] ra;

    initial begin
        rst_n = 1'b0; sltsl = 1'b1; wen = 1'b1; addr = '0; data = '0; ctrl_en = 1'b0;
        model_reset();
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        ctrl_en = 1'b1;
        tick();

        // Byte program
        dut_busy_cnt = 0; dut_done_cnt = 0;
        unlock();
        wr(16'h5555, 8'hA0);
        wr(16'h8123, 8'h5A);
        wait_idle();
        repeat (3) tick();
        chk("prog_busy_len", dut_busy_cnt, PROG);
        chk("prog_done_pulses", dut_done_cnt, 1);
        chk("prog_last_op", int'(LAST_OP), 1);
        chk("prog_cmd_err", int'(CMD_ERR), 0);

        // Sector erase
        dut_busy_cnt = 0; dut_done_cnt = 0;
        unlock(); wr(16'h5555, 8'h80); unlock(); wr(16'h6000, 8'h30);
        wait_idle();
        repeat (2) tick();
        chk("sector_busy_len", dut_busy_cnt, SEC);
        chk("sector_last_op", int'(LAST_OP), 2);

        // Chip erase
        dut_busy_cnt = 0; dut_done_cnt = 0;
        unlock(); wr(16'h5555, 8'h80); unlock(); wr(16'h5555, 8'h10);
        wait_idle();
        repeat (2) tick();
        chk("chip_busy_len", dut_busy_cnt, CHIP);
        chk("chip_last_op", int'(LAST_OP), 3);
        chk("chip_done_pulses", dut_done_cnt, 1);

        // Bad second unlock sets the sticky error; the next unlock clears it
        wr(16'h5555, 8'hAA); wr(16'h4AAA, 8'h54);
        chk("bad_unlock_err", int'(CMD_ERR), 1);
        wr(16'h5555, 8'hAA);
        chk("unlock_clears_err", int'(CMD_ERR), 0);
        wr(16'h4AAA, 8'hF0);

        // Long strobe is a single event; F0 returns to idle without error
        wr(16'h5555, 8'hAA, 5);
        wr(16'h4AAA, 8'h55);
        wr(16'h5555, 8'h90);
        chk("long_strobe_err", int'(CMD_ERR), 0);
        wr(16'h5555, 8'hAA, 5);
        wr(16'h4AAA, 8'hF0);
        chk("f0_no_err", int'(CMD_ERR), 0);

        // Writes during busy, and window disable mid-busy
        unlock(); wr(16'h5555, 8'hA0); wr(16'h9000, 8'h11);
        repeat (10) tick();
        wr(16'hA000, 8'hF0);
        chk("busy_f0_err", int'(CMD_ERR), 1);
        chk("busy_f0_still_busy", int'(FLASH_BUSY), 1);
        ctrl_en = 1'b0;
        wait_idle();
        tick();
        chk("ctrl_off_wr_block", int'(WR_BLOCK), 1);
        ctrl_en = 1'b1;
        tick();

        // Reset in the middle of a program operation
        unlock(); wr(16'h5555, 8'hA0); wr(16'h7777, 8'h33);
        while (m_rem > 40) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", int'(FLASH_BUSY), 0);
        chk("rst_last_op", int'(LAST_OP), 0);
        chk("rst_cmd_err", int'(CMD_ERR), 0);
        chk("rst_op_done", int'(OP_DONE), 0);
        model_reset();
        dut_done_cnt = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (60) tick();
        chk("rst_no_done", dut_done_cnt, 0);

        // Randomized command traffic
        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 7);
            h    = $urandom_range(1, 3);
            case (kind)
                0: begin unlock(h); wr(16'h5555, 8'hA0, h); wr(rand_win(), 8'($urandom), h); end
                1: begin unlock(h); wr(16'h5555, 8'h80, h); unlock(h); wr(rand_win(), 8'h30, h); end
                2: begin unlock(h); wr(16'h5555, 8'h80, h); unlock(h); wr(16'h5555, 8'h10, h); end
                3: begin unlock(h); wr(16'h5555, 8'h90, h); end
                4: begin
                    unlock(h);
                    pick = $urandom_range(0, 2);
                    ra = (pick == 0) ? 16'h5555 : (pick == 1) ? 16'h4AAA : rand_win();
                    wr(ra, 8'($urandom_range(0, 255)), h);
                end
                5: begin
                    for (int k = 0; k < 3; k++) wr(16'($urandom), 8'($urandom), h);
                end
                6: begin
                    wr(16'h5555, 8'hAA, h);
                    ctrl_en = 1'b0;
                    wr(16'h4AAA, 8'h55, h);
                    repeat ($urandom_range(1, 4)) tick();
                    ctrl_en = 1'b1;
                    wr(16'h5555, 8'hA0, h);
                end
                default: begin wr(16'h5555, 8'hAA, h); wr(rand_win(), 8'hF0, h); end
            endcase
            if ($urandom_range(0, 1) == 1) wait_idle();
            else repeat ($urandom_range(0, 5)) tick();
        end
        ctrl_en = 1'b1;
        wait_idle();
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
